// File: rtl/btn_pkg.sv
// Shared button indices, polarity and repeat-FSM encoding for the ship button conditioner.
package btn_pkg;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_DOWN  = 3;
    localparam int BTN_FIRE  = 4;
    localparam int BTN_N     = 5;

    localparam logic BTN_RELEASED = 1'b1;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Opposing directions held together both read as released for as long as the overlap lasts.
    function automatic logic [BTN_N-1:0] apply_lockout(input logic [BTN_N-1:0] st);
        logic lr_both;
        logic ud_both;
        logic [BTN_N-1:0] res;
        lr_both        = (st[BTN_LEFT] != BTN_RELEASED) && (st[BTN_RIGHT] != BTN_RELEASED);
        ud_both        = (st[BTN_UP]   != BTN_RELEASED) && (st[BTN_DOWN]  != BTN_RELEASED);
        res            = st;
        res[BTN_LEFT]  = st[BTN_LEFT]  | lr_both;
        res[BTN_RIGHT] = st[BTN_RIGHT] | lr_both;
        res[BTN_UP]    = st[BTN_UP]    | ud_both;
        res[BTN_DOWN]  = st[BTN_DOWN]  | ud_both;
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce counter and registered press/release pulses.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic raw_n_i,
    output logic stable_o,
    output logic press_o,
    output logic release_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic          stable_dly_q;
    logic          press_q;
    logic          release_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Debounce: accept the synchronised level only after it has differed for DEBOUNCE_CYCLES edges.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Channel state; pulses compare the two most recent stable values so they trail the change by one cycle.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q      <= BTN_RELEASED;
            sync2_q      <= BTN_RELEASED;
            stable_q     <= BTN_RELEASED;
            stable_dly_q <= BTN_RELEASED;
            cnt_q        <= {CW{1'b0}};
            press_q      <= 1'b0;
            release_q    <= 1'b0;
        end else begin
            sync1_q      <= raw_n_i;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            press_q      <= stable_dly_q & ~stable_q;
            release_q    <= ~stable_dly_q & stable_q;
        end
    end

    assign stable_o  = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/ship_button_conditioner.sv
// Conditions the five active-low ship buttons: debounce, direction lockout, edge pulses and fire strobe.
// Define BTN_AUTOREPEAT_EN to build the fire auto-repeat FSM; otherwise fire_shot is the fire press pulse.
module ship_button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 6250000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [BTN_N-1:0] key_n_raw,
    output logic             left,
    output logic             right,
    output logic             up,
    output logic             down,
    output logic             fire,
    output logic [BTN_N-1:0] press_p,
    output logic [BTN_N-1:0] release_p,
    output logic             fire_shot
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("ship_button_conditioner: illegal timing parameter");
    end

    logic [BTN_N-1:0] stable_s;
    logic [BTN_N-1:0] lock_s;
    logic [BTN_N-1:0] level_q;

    for (genvar i = 0; i < BTN_N; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clock_i  (clock),
            .reset_i  (reset),
            .raw_n_i  (key_n_raw[i]),
            .stable_o (stable_s[i]),
            .press_o  (press_p[i]),
            .release_o(release_p[i])
        );
    end

    // Lockout acts on the debounced levels only; pulses stay pre-lockout.
    always_comb begin
        lock_s = apply_lockout(stable_s);
    end

    // Level register keeps the outputs aligned with the pulse registers in the channels.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q <= {BTN_N{BTN_RELEASED}};
        end else begin
            level_q <= lock_s;
        end
    end

    assign left  = level_q[BTN_LEFT];
    assign right = level_q[BTN_RIGHT];
    assign up    = level_q[BTN_UP];
    assign down  = level_q[BTN_DOWN];
    assign fire  = level_q[BTN_FIRE];

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    rpt_state_e    rpt_state_q;
    logic [RW-1:0] rpt_cnt_q;
    logic          shot_q;
    logic          fire_held_s;

    assign fire_held_s = (stable_s[BTN_FIRE] != BTN_RELEASED);

    // IDLE is only left on the edge where stable fire first reads pressed, so that shot coincides with press_p.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rpt_state_q <= RPT_IDLE;
            rpt_cnt_q   <= {RW{1'b0}};
            shot_q      <= 1'b0;
        end else begin
            shot_q <= 1'b0;
            case (rpt_state_q)
                RPT_IDLE: begin
                    rpt_cnt_q <= {RW{1'b0}};
                    if (fire_held_s) begin
                        shot_q      <= 1'b1;
                        rpt_state_q <= RPT_DELAY;
                    end else begin
                        rpt_state_q <= RPT_IDLE;
                    end
                end
                RPT_DELAY: begin
                    if (!fire_held_s) begin
                        rpt_cnt_q   <= {RW{1'b0}};
                        rpt_state_q <= RPT_IDLE;
                    end else if (rpt_cnt_q == DELAY_LAST) begin
                        shot_q      <= 1'b1;
                        rpt_cnt_q   <= {RW{1'b0}};
                        rpt_state_q <= RPT_REPEAT;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + RW'(1);
                    end
                end
                RPT_REPEAT: begin
                    if (!fire_held_s) begin
                        rpt_cnt_q   <= {RW{1'b0}};
                        rpt_state_q <= RPT_IDLE;
                    end else if (rpt_cnt_q == PERIOD_LAST) begin
                        shot_q    <= 1'b1;
                        rpt_cnt_q <= {RW{1'b0}};
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + RW'(1);
                    end
                end
                default: begin
                    rpt_cnt_q   <= {RW{1'b0}};
                    rpt_state_q <= RPT_IDLE;
                end
            endcase
        end
    end

    assign fire_shot = shot_q;
`else
    assign fire_shot = press_p[BTN_FIRE];
`endif

endmodule
